// File: rtl/alu_rs_pkg.sv
// Shared ALU opcode encodings, boolean constants and default tag width
// for the integer ALU reservation station.
package alu_rs_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t Add   = 4'd0;
  localparam alu_op_t Minus = 4'd1;
  localparam alu_op_t Less  = 4'd2;
  localparam alu_op_t LessU = 4'd3;
  localparam alu_op_t And   = 4'd4;
  localparam alu_op_t Or    = 4'd5;
  localparam alu_op_t Xor   = 4'd6;
  localparam alu_op_t Shl   = 4'd7;
  localparam alu_op_t Shr   = 4'd8;
  localparam alu_op_t Sra   = 4'd9;
  localparam alu_op_t Eq    = 4'd10;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Default ROB tag width; the station's TAG_W must equal this.
  localparam int ROB_TAG_W = 4;

endpackage

// File: rtl/alu_rs_select.sv
// Find-first-set over an N-bit vector: lowest set index plus a valid flag.
module rs_select #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: issue with CDB bypass, CDB wakeup,
// lowest-index select toward an external combinational ALU, and a
// registered single-cycle result toward the CDB arbiter.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [3:0]       issue_op,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             ALU_ready,
  output logic [31:0]      LV,
  output logic [31:0]      RV,
  output logic [3:0]       Op,
  input  logic             ALU_success,
  input  logic [31:0]      result,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_value
);

  localparam int IDX_W = $clog2(DEPTH);

  // Control state (reset) and payload (no reset; only read while busy).
  logic [DEPTH-1:0] busy, qj_busy, qk_busy;
  alu_op_t          op_q   [DEPTH];
  logic [31:0]      vj_q   [DEPTH];
  logic [31:0]      vk_q   [DEPTH];
  logic [TAG_W-1:0] qj_q   [DEPTH];
  logic [TAG_W-1:0] qk_q   [DEPTH];
  logic [TAG_W-1:0] dest_q [DEPTH];

  logic [DEPTH-1:0] free_vec, ready_vec, busy_nxt;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             free_ok, sel_ok;
  logic             do_issue, fire, byp_j, byp_k, live;

  assign free_vec  = ~busy;
  assign ready_vec = busy & ~qj_busy & ~qk_busy;

  rs_select #(.N(DEPTH)) u_free_sel (
    .vec   (free_vec),
    .idx   (free_idx),
    .valid (free_ok)
  );

  rs_select #(.N(DEPTH)) u_ready_sel (
    .vec   (ready_vec),
    .idx   (sel_idx),
    .valid (sel_ok)
  );

  // State may only advance when globally ready and not being flushed.
  assign live      = rdy && !flush;
  assign ALU_ready = sel_ok && live;
  assign LV        = ALU_ready ? vj_q[sel_idx] : '0;
  assign RV        = ALU_ready ? vk_q[sel_idx] : '0;
  assign Op        = ALU_ready ? op_q[sel_idx] : '0;

  assign fire     = ALU_ready && ALU_success;
  assign do_issue = issue_valid && !full && free_ok && live;
  assign byp_j    = issue_qj_busy && cdb_valid && (cdb_tag == issue_qj);
  assign byp_k    = issue_qk_busy && cdb_valid && (cdb_tag == issue_qk);

  // Next occupancy: the freed slot and the issue slot never coincide
  // because the free-slot search only sees registered busy bits.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else if (rdy) begin
      if (fire)     busy_nxt[sel_idx]  = 1'b0;
      if (do_issue) busy_nxt[free_idx] = 1'b1;
    end
  end

  // Occupancy, operand-pending bits, full flag and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      qj_busy   <= '0;
      qk_busy   <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_value <= '0;
    end else begin
      busy <= busy_nxt;
      full <= &busy_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (rdy) begin
        out_valid <= fire;
        if (fire) begin
          out_tag   <= dest_q[sel_idx];
          out_value <= result;
        end
        if (cdb_valid) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && qj_busy[i] && qj_q[i] == cdb_tag) qj_busy[i] <= 1'b0;
            if (busy[i] && qk_busy[i] && qk_q[i] == cdb_tag) qk_busy[i] <= 1'b0;
          end
        end
        if (do_issue) begin
          qj_busy[free_idx] <= issue_qj_busy && !byp_j;
          qk_busy[free_idx] <= issue_qk_busy && !byp_k;
        end
      end
    end
  end

  // Operand values: CDB capture for pending operands, and issue writes.
  always_ff @(posedge clk) begin
    if (live) begin
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && qj_busy[i] && qj_q[i] == cdb_tag) vj_q[i] <= cdb_value;
          if (busy[i] && qk_busy[i] && qk_q[i] == cdb_tag) vk_q[i] <= cdb_value;
        end
      end
      if (do_issue) begin
        op_q[free_idx]   <= issue_op;
        vj_q[free_idx]   <= byp_j ? cdb_value : issue_vj;
        vk_q[free_idx]   <= byp_k ? cdb_value : issue_vk;
        qj_q[free_idx]   <= issue_qj;
        qk_q[free_idx]   <= issue_qk;
        dest_q[free_idx] <= issue_dest;
      end
    end
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU in the out-of-order core. Accepts decoded ALU operations from the issue stage with operands either as values or as pending ROB tags. Snoops the common data bus (CDB) to fill pending operands and dispatches one ready entry per cycle to the combinational ALU over its `ALU_ready`/`LV`/`RV`/`Op` → `ALU_success`/`result` interface. Registers the ALU result with the destination tag for CDB broadcast.

## Interface
- `DEPTH`, 8: number of station entries; power of two, 2..16.
- `TAG_W`, 4: ROB tag width.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rdy` input 1: global ready; low freezes all state and forces `ALU_ready`=0.
- `flush` input 1: misprediction flush; clears all entries.
- `issue_valid` input 1: issue request this cycle.
- `issue_op` input 4: ALU opcode, encodings from `constants.v`.
- `issue_vj`, `issue_vk` input 32: operand values, meaningful when the matching busy bit is 0.
- `issue_qj`, `issue_qk` input TAG_W: producer tags.
- `issue_qj_busy`, `issue_qk_busy` input 1: operand pending on its tag.
- `issue_dest` input TAG_W: destination ROB tag.
- `full` output 1: all entries busy; registered.
- `cdb_valid` input 1, `cdb_tag` input TAG_W, `cdb_value` input 32: CDB broadcast.
- `ALU_ready` output 1, `LV` output 32, `RV` output 32, `Op` output 4: ALU request, combinational from state.
- `ALU_success` input 1, `result` input 32: ALU response, same cycle.
- `out_valid` output 1, `out_tag` output TAG_W, `out_value` output 32: registered result toward the CDB arbiter/ROB.

## Operation
- Each entry holds busy, op, vj, vk, qj, qk, qj_busy, qk_busy, and dest.
- Issue: when `issue_valid`&&!`full`&&`rdy`&&!`flush`, write into the lowest-index free entry.
  - Issue-time bypass: if an operand is pending and `cdb_valid`&&`cdb_tag`==its tag in the same cycle, store `cdb_value` and clear that busy bit.
  - `issue_valid` while `full` is a protocol violation; the request is dropped and no state changes.
- Wakeup: every cycle with `cdb_valid`, each busy entry with a matching pending tag captures `cdb_value` and clears that operand's busy bit. Both operands can wake from one broadcast.
- Select: the ready set is busy entries with both operand busy bits clear, excluding the flush cycle. Pick the lowest index in the ready set.
  - Drive `ALU_ready`=1, `LV`=vj, `RV`=vk, `Op`=op.
  - If the ready set is empty, `ALU_ready`=0 and `LV`/`RV`/`Op` are don't-care, driven 0.
- Complete: on a clock edge with `ALU_ready`&&`ALU_success`:
  - free the selected entry;
  - set `out_valid`=1, `out_tag`=dest, `out_value`=`result`.
  - Otherwise `out_valid`=0 next cycle.
  - If `ALU_success`=0, the entry stays busy and is reselected.
- `full` next = (count after this cycle's issue and free)==DEPTH.
- `flush`: next cycle all busy bits are 0, `out_valid`=0, and `full`=0. Flush overrides a same-cycle issue and completion.
- `rdy` low: no issue, wakeup, or completion. `out_*` and entries hold their values.

## Timing
- Reset values: all busy=0, `full`=0, `out_valid`=0, `out_tag`=0, `out_value`=0, `ALU_ready`=0. Reset mid-operation discards all entries immediately.
- An entry issued with both operands ready in cycle N is dispatched no earlier than N+1. Its result appears on `out_*` in N+2.
- An operand woken by CDB in cycle N makes the entry dispatchable in N+1.
- Throughput: one dispatch per cycle.
- Issue into a slot freed by a completion in the same cycle is not allowed. `full` is evaluated from registered state, so a free takes effect one cycle later.
- The `out_*` result is single-cycle. There is no backpressure: the CDB arbiter must accept it or buffer it externally.

## Structure
- `constants.v` holds:
  - the ALU op encodings (`Add`, `Minus`, `Less`, ...);
  - `True`/`False`;
  - the default ROB tag width, which must match `TAG_W`.
- Sub-module `rs_select`: parameterized find-first-set over a DEPTH-bit vector, returning index and valid. It is instantiated twice, once for free-slot and once for ready-entry selection.
- The ALU stays a separate instance outside this block.

## Test plan
- Issue `Add` with vj=5, vk=7, both ready → `ALU_ready` next cycle with LV=5, RV=7; `out_valid` with value=12 and dest tag one cycle later.
- Issue with qj=3 busy; CDB tag 3, value 0x10 two cycles later → dispatch the cycle after the CDB, LV=0x10.
- Issue with qk=2 busy and `cdb_tag`=2 in the same cycle → operand captured by bypass; dispatch next cycle.
- Fill all 8 entries with dependencies on tag 9 → `full`=1 and a ninth issue is dropped. Broadcast tag 9 → eight consecutive dispatches in index order; `full` drops after the first completion.
- Assert `flush` with 4 busy entries and a dispatch in flight → next cycle `out_valid`=0, `full`=0, no dispatch; a new issue works normally.
- Hold `rdy` low for 3 cycles mid-stream, and separately pulse `rst` low mid-dispatch → no state change while frozen; after reset all outputs are at their reset values.
